fpu_resp_buffer: RTL and testbench

// - Receiving end of the FPU result handshake: accepts results leaving fpu_wrap, buffers them in

---
 rtl/fpu_resp_pkg.sv | 23 ++
 rtl/fpu_resp_fifo.sv | 70 +++++++
 rtl/fpu_resp_buffer.sv | 102 ++++++++++
 tb/tb_fpu_resp_buffer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_resp_pkg.sv
// Shared types for the FPU response buffer: IEEE status flags and the buffered entry layout.
package fpu_resp_pkg;

    localparam int unsigned DWIDTH   = 16;
    localparam int unsigned TAG_W    = 4;
    localparam int unsigned STATUS_W = 5;

    // Field order matches fpnew_pkg::status_t so packed values are interchangeable.
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    typedef struct packed {
        logic [DWIDTH-1:0] result;
        status_t           status;
        logic [TAG_W-1:0]  tag;
    } resp_entry_t;

endpackage

// File: rtl/fpu_resp_fifo.sv
// Generic DEPTH-entry FIFO with synchronous flush, occupancy count and full/empty flags.
module fpu_resp_fifo
    import fpu_resp_pkg::*;
#(
    parameter int unsigned WIDTH = $bits(resp_entry_t),
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_en, pop_en;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Full refuses a push even when a pop frees a slot in the same cycle.
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_en && !pop_en)      count_d = count_q + CNT_W'(1);
            else if (pop_en && !push_en) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fpu_resp_buffer.sv
// In-order FPU result buffer with sticky fflags accumulation.
// Optional tag-order checker enabled by defining FPU_RESP_BUF_ORDER_CHK_EN.
module fpu_resp_buffer #(
    parameter int unsigned DWIDTH = fpu_resp_pkg::DWIDTH,
    parameter int unsigned TAG_W  = fpu_resp_pkg::TAG_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       fpu_valid_i,
    output logic                       fpu_ready_o,
    input  logic [DWIDTH-1:0]          fpu_result_i,
    input  logic [4:0]                 fpu_status_i,
    input  logic [TAG_W-1:0]           fpu_tag_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [DWIDTH-1:0]          rsp_result_o,
    output logic [4:0]                 rsp_status_o,
    output logic [TAG_W-1:0]           rsp_tag_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [4:0]                 fflags_o,
    input  logic                       fflags_clr_i,
    output logic                       tag_err_o
);

    localparam int unsigned EW = DWIDTH + 5 + TAG_W;

    logic [EW-1:0]         wdata, rdata;
    logic                  full, empty, pop_fire;
    fpu_resp_pkg::status_t head_status;
    logic [4:0]            fflags_q, fflags_d;

    // Ready depends only on stored occupancy and reset, never on rsp_ready_i.
    assign fpu_ready_o = rst_ni & ~full;
    assign rsp_valid_o = ~empty;
    assign pop_fire    = rsp_valid_o & rsp_ready_i & ~flush_i;

    assign wdata        = {fpu_result_i, fpu_status_i, fpu_tag_i};
    assign rsp_result_o = rdata[EW-1 -: DWIDTH];
    assign head_status  = rdata[TAG_W +: 5];
    assign rsp_status_o = head_status;
    assign rsp_tag_o    = rdata[TAG_W-1:0];

    fpu_resp_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (fpu_valid_i & fpu_ready_o),
        .wdata_i (wdata),
        .pop_i   (rsp_ready_i),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count_o)
    );

    always_comb begin
        fflags_d = fflags_q;
        if (pop_fire)          fflags_d = (fflags_clr_i ? 5'b0 : fflags_q) | head_status;
        else if (fflags_clr_i) fflags_d = 5'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) fflags_q <= '0;
        else         fflags_q <= fflags_d;
    end

    assign fflags_o = fflags_q;

`ifdef FPU_RESP_BUF_ORDER_CHK_EN
    logic [TAG_W-1:0] exp_tag_q, exp_tag_d;
    logic             tag_err_q, tag_err_d;

    always_comb begin
        exp_tag_d = exp_tag_q;
        tag_err_d = tag_err_q;
        if (pop_fire) begin
            if (rsp_tag_o != exp_tag_q) tag_err_d = 1'b1;
            exp_tag_d = rsp_tag_o + TAG_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exp_tag_q <= '0;
            tag_err_q <= 1'b0;
        end else begin
            exp_tag_q <= exp_tag_d;
            tag_err_q <= tag_err_d;
        end
    end

    assign tag_err_o = tag_err_q;
`else
    assign tag_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_resp_buffer.sv
// Scoreboard bench for fpu_resp_buffer: driver queues expected entries, monitor pops and compares.
module tb_fpu_resp_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        fpu_valid_i = 1'b0;
    logic        fpu_ready_o;
    logic [15:0] fpu_result_i = '0;
    logic [4:0]  fpu_status_i = '0;
    logic [3:0]  fpu_tag_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [15:0] rsp_result_o;
    logic [4:0]  rsp_status_o;
    logic [3:0]  rsp_tag_o;
    logic [2:0]  count_o;
    logic [4:0]  fflags_o;
    logic        fflags_clr_i = 1'b0;
    logic        tag_err_o;

    always #5 clk = ~clk;

    fpu_resp_buffer #(
        .DWIDTH (16),
        .TAG_W  (4),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush_i),
        .fpu_valid_i  (fpu_valid_i),
        .fpu_ready_o  (fpu_ready_o),
        .fpu_result_i (fpu_result_i),
        .fpu_status_i (fpu_status_i),
        .fpu_tag_i    (fpu_tag_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_result_o (rsp_result_o),
        .rsp_status_o (rsp_status_o),
        .rsp_tag_o    (rsp_tag_o),
        .count_o      (count_o),
        .fflags_o     (fflags_o),
        .fflags_clr_i (fflags_clr_i),
        .tag_err_o    (tag_err_o)
    );

    typedef struct {
        logic [15:0] res;
        logic [4:0]  st;
        logic [3:0]  tag;
    } ent_t;

    ent_t       exp_q[$];
    ent_t       mon_e;
    int         n_chk = 0;
    int         n_pass = 0;
    int         pre_size = 0;
    bit         mon_en = 1'b0;
    bit         popped;
    logic [4:0] m_fflags = '0;
    logic       m_err = 1'b0;
    int         m_exp_tag = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // Monitor: checks visible state against the model queue, then retires observed pops.
    always @(negedge clk) begin
        if (mon_en) begin
            pre_size = exp_q.size();
            chk("count", 32'(count_o), 32'(pre_size));
            chk("rsp_valid", 32'(rsp_valid_o), 32'(pre_size != 0));
            chk("fpu_ready", 32'(fpu_ready_o), 32'(pre_size != DEPTH));
            chk("fflags", 32'(fflags_o), 32'(m_fflags));
            chk("tag_err", 32'(tag_err_o), 32'(m_err));
            popped = !flush_i && rsp_ready_i && pre_size != 0;
            if (popped) begin
                mon_e = exp_q.pop_front();
                chk("rsp_result", 32'(rsp_result_o), 32'(mon_e.res));
                chk("rsp_status", 32'(rsp_status_o), 32'(mon_e.st));
                chk("rsp_tag", 32'(rsp_tag_o), 32'(mon_e.tag));
                m_fflags = (fflags_clr_i ? 5'b0 : m_fflags) | mon_e.st;
`ifdef FPU_RESP_BUF_ORDER_CHK_EN
                if (int'(mon_e.tag) != m_exp_tag) m_err = 1'b1;
                m_exp_tag = (int'(mon_e.tag) + 1) % 16;
`endif
            end else if (fflags_clr_i) begin
                m_fflags = 5'b0;
            end
            if (flush_i) exp_q.delete();
        end
    end

    // One clock with the current inputs; queue the push if the model says it is accepted.
    task automatic cycle();
        @(negedge clk);
        #1;
        if (mon_en && !flush_i && fpu_valid_i && pre_size < DEPTH)
            exp_q.push_back('{res: fpu_result_i, st: fpu_status_i, tag: fpu_tag_i});
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] r, input logic [4:0] s,
                         input logic [3:0] t, input logic rdy, input logic fl, input logic clr);
        fpu_valid_i  = v;
        fpu_result_i = r;
        fpu_status_i = s;
        fpu_tag_i    = t;
        rsp_ready_i  = rdy;
        flush_i      = fl;
        fflags_clr_i = clr;
        cycle();
    endtask

    task automatic idle_pop(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 5'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    endtask

    logic [4:0] saved_ff;

    initial begin
        #12;
        chk("reset_ready", 32'(fpu_ready_o), 32'd0);
        chk("reset_valid", 32'(rsp_valid_o), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("post_reset_valid", 32'(rsp_valid_o), 32'd0);
        chk("post_reset_count", 32'(count_o), 32'd0);
        chk("post_reset_fflags", 32'(fflags_o), 32'd0);
        chk("post_reset_ready", 32'(fpu_ready_o), 32'd1);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Single entry, NX status
        drive(1'b1, 16'h3C00, 5'b00001, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("first_valid", 32'(rsp_valid_o), 32'd1);
        chk("first_result", 32'(rsp_result_o), 32'h3C00);
        idle_pop(1);
        chk("fflags_nx", 32'(fflags_o), 32'b00001);

        // Fill to full, refused fifth push, drain
        for (int i = 0; i < 4; i++)
            drive(1'b1, 16'($urandom), 5'($urandom), 4'(i), 1'b0, 1'b0, 1'b0);
        chk("full_count", 32'(count_o), 32'd4);
        chk("full_ready", 32'(fpu_ready_o), 32'd0);
        drive(1'b1, 16'hDEAD, 5'h0, 4'h9, 1'b0, 1'b0, 1'b0);
        chk("fifth_ignored", 32'(count_o), 32'd4);
        idle_pop(4);
        chk("drained", 32'(count_o), 32'd0);

        // Full with simultaneous push and pop: pop only
        for (int i = 4; i < 8; i++)
            drive(1'b1, 16'($urandom), 5'h0, 4'(i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'hBEEF, 5'h0, 4'h8, 1'b1, 1'b0, 1'b0);
        chk("full_pushpop_count", 32'(count_o), 32'd3);
        chk("full_pushpop_ready", 32'(fpu_ready_o), 32'd1);
        idle_pop(3);

        // Flush with concurrent push
        drive(1'b1, 16'h1111, 5'b00100, 4'h9, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h2222, 5'b01000, 4'hA, 1'b0, 1'b0, 1'b0);
        saved_ff = m_fflags;
        drive(1'b1, 16'h3333, 5'b00010, 4'hB, 1'b0, 1'b1, 1'b0);
        chk("flush_count", 32'(count_o), 32'd0);
        chk("flush_valid", 32'(rsp_valid_o), 32'd0);
        chk("flush_fflags", 32'(fflags_o), 32'(saved_ff));

        // Pop NV while clearing
        drive(1'b1, 16'h4444, 5'b10000, 4'hC, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'h0, 5'h0, 4'h0, 1'b1, 1'b0, 1'b1);
        chk("clr_pop_fflags", 32'(fflags_o), 32'b10000);

        // Out-of-order tags 0 then 2
        drive(1'b1, 16'h5555, 5'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h6666, 5'h0, 4'h2, 1'b0, 1'b0, 1'b0);
        idle_pop(2);
`ifdef FPU_RESP_BUF_ORDER_CHK_EN
        chk("tag_err_set", 32'(tag_err_o), 32'd1);
`else
        chk("tag_err_tied", 32'(tag_err_o), 32'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            drive(1'($urandom), 16'($urandom), 5'($urandom), 4'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0),
                  1'($urandom_range(0, 15) == 0));
        idle_pop(6);
        chk("final_empty", 32'(count_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
